operand_entry_ctrl: RTL and testbench

OPERAND_ENTRY_CTRL -- requirements
Module: operand_entry_ctrl

---
 rtl/operand_entry_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_operand_entry_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/operand_entry_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// operand_entry_ctrl
//
// Purpose: operand entry front end for a 4-bit add/sub calculator. Two raw
// push buttons are synchronized and debounced. "enter" walks a three-state
// FSM that latches operand A, then operand B, then flags the result valid.
// "op" toggles the add/subtract select in any state.
//
// Ports:
//   clk_main        in   system clock, rising edge
//   reset           in   asynchronous active-high reset
//   sw[3:0]         in   raw slide switches (asynchronous)
//   btn_enter       in   raw bouncing button, advances entry
//   btn_op          in   raw bouncing button, toggles Sub
//   A[3:0]          out  registered operand A
//   B[3:0]          out  registered operand B
//   Sub             out  registered op select (0 add, 1 subtract)
//   operands_valid  out  registered, high exactly while in READY
//   entry_state[1:0]out  FSM state (00 LOAD_A, 01 LOAD_B, 10 READY)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// operand_entry_debounce
//
// Purpose: debounce one already-synchronized button level and emit a
// registered one-cycle pulse on each accepted 0->1 transition.
//
// Ports:
//   clk_main  in   clock
//   reset     in   asynchronous active-high reset
//   i_level   in   synchronized raw level
//   o_pulse   out  one-cycle pulse, DEBOUNCE_CYCLES+1 cycles after the first
//                  synchronized-high cycle
// -----------------------------------------------------------------------------
module operand_entry_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_main,
  input  logic reset,
  input  logic i_level,
  output logic o_pulse
);

  localparam logic [23:0] CNT_MAX = 24'(DEBOUNCE_CYCLES - 1);

  logic [23:0] r_cnt;
  logic        r_level;
  logic        r_level_d;
  logic        r_pulse;
  logic        w_differ;
  logic        w_at_max;

  assign w_differ = (i_level != r_level);
  assign w_at_max = (r_cnt == CNT_MAX);

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_level_d <= r_level;
      // Edge detect on the debounced level: pulse lands one cycle after the
      // level flips, which keeps press latency fixed at DEBOUNCE_CYCLES+1.
      r_pulse   <= r_level & ~r_level_d;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_at_max) begin
        r_level <= i_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 24'd1;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

module operand_entry_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk_main,
  input  logic       reset,
  input  logic [3:0] sw,
  input  logic       btn_enter,
  input  logic       btn_op,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       Sub,
  output logic       operands_valid,
  output logic [1:0] entry_state
);

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'b00,
    ST_LOAD_B = 2'b01,
    ST_READY  = 2'b10
  } state_t;

  // Two-flop synchronizers for every asynchronous input.
  logic [3:0] r_sw_s1, r_sw_s2;
  logic       r_en_s1, r_en_s2;
  logic       r_op_s1, r_op_s2;

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
      r_en_s1 <= 1'b0;
      r_en_s2 <= 1'b0;
      r_op_s1 <= 1'b0;
      r_op_s2 <= 1'b0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
      r_en_s1 <= btn_enter;
      r_en_s2 <= r_en_s1;
      r_op_s1 <= btn_op;
      r_op_s2 <= r_op_s1;
    end
  end

  logic w_enter_p;
  logic w_op_p;

  operand_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enter (
    .clk_main (clk_main),
    .reset    (reset),
    .i_level  (r_en_s2),
    .o_pulse  (w_enter_p)
  );

  operand_entry_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_op (
    .clk_main (clk_main),
    .reset    (reset),
    .i_level  (r_op_s2),
    .o_pulse  (w_op_p)
  );

  state_t     r_state;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic       r_sub;
  logic       r_valid;

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      r_state <= ST_LOAD_A;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (w_enter_p) begin
        case (r_state)
          ST_LOAD_A: begin
            r_a     <= r_sw_s2;
            r_state <= ST_LOAD_B;
            r_valid <= 1'b0;
          end
          ST_LOAD_B: begin
            r_b     <= r_sw_s2;
            r_state <= ST_READY;
            r_valid <= 1'b1;
          end
          ST_READY: begin
            r_state <= ST_LOAD_A;
            r_valid <= 1'b0;
          end
          default: begin
            r_state <= ST_LOAD_A;
            r_valid <= 1'b0;
          end
        endcase
      end
      // Operation toggle is independent of the entry FSM and may coincide
      // with an enter pulse on the same edge.
      if (w_op_p) begin
        r_sub <= ~r_sub;
      end
    end
  end

  assign A              = r_a;
  assign B              = r_b;
  assign Sub            = r_sub;
  assign operands_valid = r_valid;
  assign entry_state    = r_state;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
`timescale 1ns/1ps
module tb_operand_entry_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk_main = 1'b0;
  logic       reset;
  logic [3:0] sw;
  logic       btn_enter;
  logic       btn_op;
  logic [3:0] A;
  logic [3:0] B;
  logic       Sub;
  logic       operands_valid;
  logic [1:0] entry_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_main = ~clk_main;

  operand_entry_ctrl #(.DEBOUNCE_CYCLES(8)) dut (
    .clk_main       (clk_main),
    .reset          (reset),
    .sw             (sw),
    .btn_enter      (btn_enter),
    .btn_op         (btn_op),
    .A              (A),
    .B              (B),
    .Sub            (Sub),
    .operands_valid (operands_valid),
    .entry_state    (entry_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_main);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Buttons driven just after an edge: the FSM reacts on the 12th edge
  // (2 sync + DEBOUNCE_CYCLES + 1 pulse + 1 capture). Before that, state and
  // Sub must not move.
  task automatic press(input logic en, input logic op,
                       input logic [1:0] exp_state, input logic exp_sub);
    btn_enter = en;
    btn_op    = op;
    for (int i = 0; i < 11; i++) begin
      tick();
      check("hold_state", entry_state, exp_state);
      check("hold_sub", Sub, exp_sub);
    end
    tick();
  endtask

  task automatic release_btns();
    btn_enter = 1'b0;
    btn_op    = 1'b0;
    repeat (14) tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; sw = 4'h0; btn_enter = 1'b0; btn_op = 1'b0;
    repeat (3) tick();
    check("rst_A", A, 4'h0);
    check("rst_B", B, 4'h0);
    check("rst_sub", Sub, 1'b0);
    check("rst_valid", operands_valid, 1'b0);
    check("rst_state", entry_state, 2'b00);
    #2 reset = 1'b0;
    tick();

    // Entry sequence A=5, B=3, then back to LOAD_A
    sw = 4'h5;
    press(1'b1, 1'b0, 2'b00, 1'b0);
    check("ea_state", entry_state, 2'b01);
    check("ea_A", A, 4'h5);
    check("ea_valid", operands_valid, 1'b0);
    release_btns();
    sw = 4'h3;
    press(1'b1, 1'b0, 2'b01, 1'b0);
    check("eb_state", entry_state, 2'b10);
    check("eb_B", B, 4'h3);
    check("eb_A", A, 4'h5);
    check("eb_valid", operands_valid, 1'b1);
    release_btns();
    press(1'b1, 1'b0, 2'b10, 1'b0);
    check("er_state", entry_state, 2'b00);
    check("er_valid", operands_valid, 1'b0);
    check("er_A", A, 4'h5);
    check("er_B", B, 4'h3);
    release_btns();

    // Sub toggling 1,0,1 then back to 0
    press(1'b0, 1'b1, 2'b00, 1'b0);
    check("op1_sub", Sub, 1'b1);
    release_btns();
    press(1'b0, 1'b1, 2'b00, 1'b1);
    check("op2_sub", Sub, 1'b0);
    release_btns();
    press(1'b0, 1'b1, 2'b00, 1'b0);
    check("op3_sub", Sub, 1'b1);
    check("op3_state", entry_state, 2'b00);
    check("op3_A", A, 4'h5);
    check("op3_B", B, 4'h3);
    release_btns();
    press(1'b0, 1'b1, 2'b00, 1'b1);
    check("op4_sub", Sub, 1'b0);
    release_btns();

    // Latch timing: sw changes right after the capture
    sw = 4'h2;
    press(1'b1, 1'b0, 2'b00, 1'b0);
    sw = 4'h7;
    release_btns();
    check("latch_A", A, 4'h2);
    check("latch_state", entry_state, 2'b01);

    // Simultaneous enter + op in LOAD_B
    sw = 4'hA;
    press(1'b1, 1'b1, 2'b01, 1'b0);
    check("sim_B", B, 4'hA);
    check("sim_sub", Sub, 1'b1);
    check("sim_state", entry_state, 2'b10);
    check("sim_valid", operands_valid, 1'b1);
    check("sim_A", A, 4'h2);
    release_btns();

    // Build READY with A=F, B=1, Sub=1
    press(1'b1, 1'b0, 2'b10, 1'b1);
    release_btns();
    sw = 4'hF;
    press(1'b1, 1'b0, 2'b00, 1'b1);
    release_btns();
    sw = 4'h1;
    press(1'b1, 1'b0, 2'b01, 1'b1);
    release_btns();
    check("pre_A", A, 4'hF);
    check("pre_B", B, 4'h1);
    check("pre_state", entry_state, 2'b10);
    check("pre_valid", operands_valid, 1'b1);

    // Asynchronous reset pulse between edges with btn_enter held
    sw = 4'h6;
    btn_enter = 1'b1;
    #3;
    reset = 1'b1;
    #0.5;
    check("ar_A", A, 4'h0);
    check("ar_B", B, 4'h0);
    check("ar_sub", Sub, 1'b0);
    check("ar_valid", operands_valid, 1'b0);
    check("ar_state", entry_state, 2'b00);
    #0.5;
    reset = 1'b0;
    // Pulse on edge DEBOUNCE_CYCLES+3 = 11 after release, capture on 12.
    for (int i = 0; i < 11; i++) begin
      tick();
      check("ar_wait_state", entry_state, 2'b00);
    end
    tick();
    check("ar_press_state", entry_state, 2'b01);
    check("ar_press_A", A, 4'h6);
    release_btns();

    // Bounce rejection in LOAD_B: 3-cycle high/low toggling for 40 cycles
    sw = 4'h9;
    for (int i = 0; i < 40; i++) begin
      btn_enter = ((i / 3) % 2) == 0;
      tick();
      check("bounce_state", entry_state, 2'b01);
    end
    press(1'b1, 1'b0, 2'b01, 1'b0);
    check("bounce_state_end", entry_state, 2'b10);
    check("bounce_B", B, 4'h9);
    check("bounce_valid", operands_valid, 1'b1);
    // Held high indefinitely: no further pulse
    for (int i = 0; i < 30; i++) begin
      tick();
      check("held_state", entry_state, 2'b10);
    end
    release_btns();
    check("final_state", entry_state, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
